video_timing_driver: RTL and testbench
======================================

Name: video_timing_driver

Overview:
- Display-side timing engine for the HDMI colour-bar path; the counterpart of the pixel generator, which consumes coordinates and returns colour.
- Generates 800x600@60 SVGA (40 MHz pixel clock) HSYNC/VSYNC/DE.
- Issues pixel_xpos/pixel_ypos requests one cycle ahead to cover the generator's 1-cycle registered latency, then samples the returned pixel_data into an aligned RGB output for the TMDS encoder.

Parameters:
- H_SYNC, 128, hsync pulse width (pixels)
- H_BACK, 88, horizontal back porch
- H_DISP, 800, horizontal active pixels
- H_FRONT, 40, horizontal front porch
- V_SYNC, 4, vsync pulse width (lines)
- V_BACK, 23, vertical back porch
- V_DISP, 600, vertical active lines
- V_FRONT, 1, vertical front porch
- Derived, not overridable:
  - H_TOTAL = 1056, V_TOTAL = 628
  - HA = H_SYNC + H_BACK = 216
  - VA = V_SYNC + V_BACK = 27

Ports:
- pixel_clk  in  1  pixel clock, 40 MHz
- sys_rst_n  in  1  asynchronous active-low reset
- pixel_data  in  24  RGB888 from the generator; registered by it one cycle after the request
- pixel_xpos  out  11  requested column, 0..799; 0 when no request
- pixel_ypos  out  11  requested row, 0..599; 0 when no request
- video_hs  out  1  horizontal sync, active high
- video_vs  out  1  vertical sync, active high
- video_de  out  1  data enable
- video_rgb  out  24  pixel colour; 0 when video_de = 0

Behaviour:
- Clock and reset
  - One clock (pixel_clk).
  - sys_rst_n is asynchronous, active-low.
- Counters
  - h_cnt: 11 bits, 0..H_TOTAL-1, increments every cycle; wraps to 0 after 1055.
  - v_cnt: 11 bits, increments when h_cnt wraps; wraps to 0 when h_cnt = 1055 and v_cnt = 627.
  - No other values are reachable.
- Request (combinational from the counters)
  - req = (HA-1 <= h_cnt < HA+H_DISP-1) && (VA <= v_cnt < VA+V_DISP).
  - pixel_xpos = req ? h_cnt-(HA-1) : 0.
  - pixel_ypos = req ? v_cnt-VA : 0.
  - All subtractions are 11-bit and never negative within the region.
- Outputs (all registered from the same counter value, so all four lag the counters by exactly one cycle and are mutually aligned)
  - video_hs <= (h_cnt < H_SYNC).
  - video_vs <= (v_cnt < V_SYNC), held for whole lines including the porches of those lines.
  - video_de <= (HA <= h_cnt < HA+H_DISP) && (VA <= v_cnt < VA+V_DISP).
  - video_rgb <= (same condition as video_de) ? pixel_data : 24'd0.
- Latency
  - Request for column x is issued at h_cnt = HA-1+x.
  - The generator presents that column's colour at h_cnt = HA+x.
  - video_rgb carries it, with video_de = 1, in the following cycle.
  - End-to-end: 2 cycles from request to output.
- Per-frame counts
  - Exactly 800 de-high cycles per active line and 600 active lines: 480000 per frame.
  - Frame period is 663168 cycles.
- Reset (asserted at any time, including mid-line or mid-frame)
  - Immediately forces h_cnt = v_cnt = 0 and video_hs = video_vs = video_de = 0, video_rgb = 0.
  - pixel_xpos and pixel_ypos follow the counters, so they are 0.
  - On release, counting restarts at (0,0); video_hs and video_vs rise after the first clock edge. No partial-frame recovery.
- Boundaries
  - Last request of a line is at h_cnt = 1014 (xpos 799); the last de-high output comes from h_cnt = 1015.
  - Request does not wrap across lines.
  - v_cnt is unchanged by h_cnt values other than 1055.
  - Front-porch cycles produce video_rgb = 0 regardless of pixel_data.

Test Plan:
- Reset: hold sys_rst_n = 0 for 5 cycles, toggling pixel_data -> all outputs 0, pixel_xpos = pixel_ypos = 0; first edge after release -> video_hs = 1, video_vs = 1.
- Horizontal timing: run 3 lines -> video_hs period 1056 cycles, high for 128; video_de high for 800 consecutive cycles starting 216 cycles after the hs rising edge, on active lines only.
- Vertical timing: run 2 full frames -> video_vs period 663168 cycles, high for 4224 (4 lines); 600 lines contain de; 480000 de-high cycles per frame.
- Request sequence: monitor pixel_xpos on line v_cnt = 27 -> 0 until h_cnt = 215, then 0,1,...,799, then 0; pixel_ypos = 0 on that line and 599 on v_cnt = 626; both 0 on v_cnt = 627.
- Alignment: connect the 8-band colour-bar generator (1-cycle registered) -> first de pixel is FFFFFF; de pixels 100..199 are FFFF00; pixels 600..699 are 000000; pixels 700..799 are 0000FF; no off-by-one at band edges (pixel 99 = FFFFFF, pixel 100 = FFFF00).
- Mid-frame reset: assert sys_rst_n = 0 at v_cnt = 300, h_cnt = 500 -> outputs go 0 asynchronously without waiting for an edge; after release a full vsync pulse (4224 cycles) occurs before the first de-high cycle.

Source files
------------

// File: rtl/video_timing_driver.sv
// video_timing_driver
//   Display-side timing engine for an 800x600@60 SVGA stream (40 MHz pixel
//   clock). Free-running horizontal/vertical counters produce HSYNC, VSYNC
//   and DE. Pixel coordinates are requested one cycle early so that a pixel
//   generator with a one-cycle registered latency can return colour in time
//   to be registered alongside DE.
//
// Ports
//   pixel_clk   in   pixel clock
//   sys_rst_n   in   asynchronous active-low reset
//   pixel_data  in   RGB888 returned by the generator, one cycle after request
//   pixel_xpos  out  requested column (0 when no request)
//   pixel_ypos  out  requested row (0 when no request)
//   video_hs    out  horizontal sync, active high
//   video_vs    out  vertical sync, active high (whole lines)
//   video_de    out  data enable
//   video_rgb   out  pixel colour, 0 outside the active area
module video_timing_driver #(
  parameter int unsigned H_SYNC  = 128,
  parameter int unsigned H_BACK  = 88,
  parameter int unsigned H_DISP  = 800,
  parameter int unsigned H_FRONT = 40,
  parameter int unsigned V_SYNC  = 4,
  parameter int unsigned V_BACK  = 23,
  parameter int unsigned V_DISP  = 600,
  parameter int unsigned V_FRONT = 1
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic [23:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_de,
  output logic [23:0] video_rgb
);

  // Start of the active area measured from the start of the sync pulse.
  localparam int unsigned HA_I = H_SYNC + H_BACK;
  localparam int unsigned VA_I = V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST      = 11'(HA_I + H_DISP + H_FRONT - 1);
  localparam logic [10:0] V_LAST      = 11'(VA_I + V_DISP + V_FRONT - 1);
  localparam logic [10:0] H_SYNC_END  = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_END  = 11'(V_SYNC);
  localparam logic [10:0] H_DE_START  = 11'(HA_I);
  localparam logic [10:0] H_DE_END    = 11'(HA_I + H_DISP);
  localparam logic [10:0] H_REQ_START = 11'(HA_I - 1);
  localparam logic [10:0] H_REQ_END   = 11'(HA_I + H_DISP - 1);
  localparam logic [10:0] V_ACT_START = 11'(VA_I);
  localparam logic [10:0] V_ACT_END   = 11'(VA_I + V_DISP);

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        h_last;
  logic        v_last;
  logic        v_active;
  logic        req;
  logic        de_next;

  always_comb begin
    h_last   = (h_cnt == H_LAST);
    v_last   = (v_cnt == V_LAST);
    v_active = (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
    // The request window is the DE window shifted one pixel earlier; it
    // ends before the line wraps, so it never spills into the next line.
    req      = v_active && (h_cnt >= H_REQ_START) && (h_cnt < H_REQ_END);
    de_next  = v_active && (h_cnt >= H_DE_START) && (h_cnt < H_DE_END);
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 11'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  always_comb begin
    pixel_xpos = '0;
    pixel_ypos = '0;
    if (req) begin
      pixel_xpos = h_cnt - H_REQ_START;
      pixel_ypos = v_cnt - V_ACT_START;
    end
  end

  // All four outputs are registered from the same counter value so they
  // stay mutually aligned, one cycle behind the counters. pixel_data at
  // this point belongs to the request issued on the previous cycle.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      video_hs  <= 1'b0;
      video_vs  <= 1'b0;
      video_de  <= 1'b0;
      video_rgb <= '0;
    end else begin
      video_hs  <= (h_cnt < H_SYNC_END);
      video_vs  <= (v_cnt < V_SYNC_END);
      video_de  <= de_next;
      video_rgb <= de_next ? pixel_data : '0;
    end
  end

endmodule

// File: tb/tb_video_timing_driver.sv
// Testbench for video_timing_driver.
// Two instances run side by side: the default 800x600 timing driven by an
// emulated 8-band colour-bar generator (1-cycle registered), and a tiny
// timing driven with random pixel data and random mid-frame resets so that
// whole frames fit in a short run. A reference model derives every expected
// output from the linear position within the frame.
module tb_video_timing_driver;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
    logic [10:0] x;
    logic [10:0] y;
  } obs_t;

  typedef struct {
    int hs, hb, hd, hf, vs, vb, vd, vf;
  } tim_t;

  localparam int NCYC = 31 * 1056;

  logic        clk = 1'b0;
  logic        rst_a = 1'b0;
  logic        rst_b = 1'b0;
  logic [23:0] data_a = '0;
  logic [23:0] data_b = '0;
  logic [10:0] xpos_a, ypos_a, xpos_b, ypos_b;
  logic        hs_a, vs_a, de_a, hs_b, vs_b, de_b;
  logic [23:0] rgb_a, rgb_b;

  obs_t qa[$];
  obs_t qb[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 0;

  always #5 clk = ~clk;

  video_timing_driver u_big (
    .pixel_clk (clk),
    .sys_rst_n (rst_a),
    .pixel_data(data_a),
    .pixel_xpos(xpos_a),
    .pixel_ypos(ypos_a),
    .video_hs  (hs_a),
    .video_vs  (vs_a),
    .video_de  (de_a),
    .video_rgb (rgb_a)
  );

  video_timing_driver #(
    .H_SYNC (4),
    .H_BACK (3),
    .H_DISP (10),
    .H_FRONT(2),
    .V_SYNC (2),
    .V_BACK (2),
    .V_DISP (5),
    .V_FRONT(1)
  ) u_small (
    .pixel_clk (clk),
    .sys_rst_n (rst_b),
    .pixel_data(data_b),
    .pixel_xpos(xpos_b),
    .pixel_ypos(ypos_b),
    .video_hs  (hs_b),
    .video_vs  (vs_b),
    .video_de  (de_b),
    .video_rgb (rgb_b)
  );

  function automatic logic [23:0] bar(input int x, input int hd);
    int i;
    i = x * 8 / hd;
    case (i)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h000000;
      default: return 24'h0000FF;
    endcase
  endfunction

  // pos counts clock edges since reset release; the counters sit at frame
  // position pos, the registered outputs describe position pos-1.
  function automatic obs_t model(input tim_t t, input int pos, input bit rst,
                                 input bit bar_mode, input logic [23:0] dlast);
    obs_t e;
    int ht, vt, ha, va, p, col, line;
    e  = '0;
    ht = t.hs + t.hb + t.hd + t.hf;
    vt = t.vs + t.vb + t.vd + t.vf;
    ha = t.hs + t.hb;
    va = t.vs + t.vb;
    if (rst) begin
      p    = pos % (ht * vt);
      col  = p % ht;
      line = p / ht;
      if (line >= va && line < va + t.vd && col >= ha - 1 && col < ha - 1 + t.hd) begin
        e.x = 11'(col - ha + 1);
        e.y = 11'(line - va);
      end
      if (pos > 0) begin
        p    = (pos - 1) % (ht * vt);
        col  = p % ht;
        line = p / ht;
        e.hs = (col < t.hs);
        e.vs = (line < t.vs);
        e.de = (line >= va && line < va + t.vd && col >= ha && col < ha + t.hd);
        if (e.de) e.rgb = bar_mode ? bar(col - ha, t.hd) : dlast;
      end
    end
    return e;
  endfunction

  task automatic compare(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got hs=%b vs=%b de=%b rgb=%h x=%0d y=%0d required hs=%b vs=%b de=%b rgb=%h x=%0d y=%0d",
               name, $time, got.hs, got.vs, got.de, got.rgb, got.x, got.y,
               exp.hs, exp.vs, exp.de, exp.rgb, exp.x, exp.y);
    end
  endtask

  // Monitor: pops one expectation per instance each cycle, away from the edge.
  initial begin
    obs_t ea, eb;
    while (!done) begin
      @(negedge clk);
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        compare("big", {hs_a, vs_a, de_a, rgb_a, xpos_a, ypos_a}, ea);
      end
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        compare("small", {hs_b, vs_b, de_b, rgb_b, xpos_b, ypos_b}, eb);
      end
    end
  end

  // Stimulus: reset sequencing, generator emulation, expectation push.
  initial begin
    tim_t        ta, tb;
    int          pos_a, pos_b, cd_b, hold_b;
    logic [10:0] xprev_a;
    logic [23:0] dlast_b;
    ta = '{128, 88, 800, 40, 4, 23, 600, 1};
    tb = '{4, 3, 10, 2, 2, 2, 5, 1};
    pos_a   = 0;
    pos_b   = 0;
    cd_b    = 0;
    hold_b  = 0;
    xprev_a = '0;
    dlast_b = '0;
    for (int c = 0; c < NCYC && errors < 40; c++) begin
      @(posedge clk);
      if (rst_a) pos_a++;
      if (rst_b) pos_b++;
      #1;
      if (c == 5) begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        cd_b  = $urandom_range(150, 700);
      end else if (c > 5) begin
        if (rst_b) begin
          cd_b--;
          if (cd_b == 0) begin
            rst_b  = 1'b0;      // asserted between edges
            pos_b  = 0;
            hold_b = $urandom_range(1, 4);
          end
        end else begin
          hold_b--;
          if (hold_b == 0) begin
            rst_b = 1'b1;
            cd_b  = $urandom_range(150, 700);
          end
        end
      end
      #1;
      qa.push_back(model(ta, pos_a, rst_a, 1'b1, '0));
      qb.push_back(model(tb, pos_b, rst_b, 1'b0, dlast_b));
      // Registered colour-bar generator: returns the colour for the
      // coordinate requested on the previous cycle; noise while in reset.
      data_a  = rst_a ? bar(int'(xprev_a), 800) : 24'($urandom());
      xprev_a = xpos_a;
      dlast_b = 24'($urandom());
      data_b  = dlast_b;
    end
    @(negedge clk);
    done = 1;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
